iccm_port_arbiter: RTL and testbench
====================================

// Module: iccm_port_arbiter
// PURPOSE
//  Shares the single-port ICCM SRAM (1rw, active-low csb/web) between the UART boot-programming writer and the
//  TL-UL instruction/data adapter side. Buffers programming writes, arbitrates per cycle with starvation
//  protection for the bus, and sequences a programming session that locks out the bus until all writes land.
//  Sits between iccm_controller / instr_mem_top and the sky130 ICCM macro.
// PARAMETERS
//  AW          10  SRAM word-address width
//  DW          32  data width (wmask width = DW/8)
//  PBUF_DEPTH  2   prog write buffer entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive denied bus_req cycles before bus is forced to win
// PORTS
//  clk_i         in   1      clock
//  rst_i         in   1      async reset, active high
//  prog_mode_i   in   1      programming session active (level)
//  prog_we_i     in   1      prog write strobe, one word per cycle
//  prog_addr_i   in   AW     prog write word address
//  prog_wdata_i  in   DW     prog write data
//  prog_full_o   out  1      prog buffer full
//  prog_ovf_o    out  1      sticky: prog write dropped (buffer full)
//  bus_req_i     in   1      bus request (held until bus_gnt_o)
//  bus_we_i      in   1      bus write (1) / read (0)
//  bus_addr_i    in   AW     bus word address
//  bus_wdata_i   in   DW     bus write data
//  bus_wmask_i   in   DW/8   bus byte mask
//  bus_gnt_o     out  1      request accepted this cycle (combinational)
//  bus_rvalid_o  out  1      response, exactly 1 cycle after gnt
//  bus_rdata_o   out  DW     read data, valid with rvalid on reads; 0 on writes
//  sram_csb_o    out  1      active-low chip select
//  sram_web_o    out  1      active-low write enable
//  sram_wmask_o  out  DW/8   byte mask
//  sram_addr_o   out  AW     address
//  sram_din_o    out  DW     write data
//  sram_dout_i   in   DW     read data, valid cycle after access
//  busy_o        out  1      state != RUN or buffer non-empty
// BEHAVIOUR
//  Reset: buffer empty, starve cnt 0, state RUN, prog_full_o=0, prog_ovf_o=0, bus_gnt_o=0, bus_rvalid_o=0,
//   bus_rdata_o=0, sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_din_o=0, busy_o=0.
//   Reset mid-operation discards buffered writes and any pending rvalid.
//  Buffer: FIFO, push on prog_we_i when not full; push when full -> word dropped, prog_ovf_o set (sticky until reset).
//   Simultaneous push+pop when full is legal (no drop). Pointers wrap modulo PBUF_DEPTH.
//  FSM: RUN  -> PROG on prog_mode_i=1.
//       PROG -> DRAIN on prog_mode_i=0; bus_gnt_o forced 0 in PROG.
//       DRAIN-> RUN when buffer empty (and not pushing); bus_gnt_o forced 0. prog_mode_i=1 in DRAIN -> PROG.
//  Arbitration (combinational, per cycle):
//   PROG/DRAIN: pop buffer head to SRAM if non-empty.
//   RUN: buffer empty -> bus wins if bus_req_i; non-empty and no req -> prog; both -> prog unless
//    starve cnt==STARVE_MAX, then bus wins.
//   Starve cnt: +1 each cycle bus_req_i=1 and gnt=0 (saturating); cleared on bus grant or bus_req_i=0.
//  SRAM drive: idle csb=1,web=1. Prog pop: csb=0,web=0,wmask=all 1s, addr/din from head.
//   Bus grant: csb=0, web=~bus_we_i, wmask=bus_wmask_i (reads: wmask 0), addr/din from bus.
//  Response: bus_rvalid_o registered 1 cycle after gnt; bus_rdata_o = sram_dout_i when rvalid on a read, else 0.
//   Back-to-back grants give back-to-back rvalid; no backpressure on response.
//  prog_full_o = count==PBUF_DEPTH (registered count). busy_o combinational from state/count.
// CONFIGURATION
//  ICCM_ARB_WCOUNT_EN defined: adds output prog_wcount_o [AW:0]: committed prog writes (SRAM pops), reset 0,
//   cleared on RUN->PROG transition, saturates at all-ones.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  Bus read only, addr 0x010 with SRAM model holding 0xDEADBEEF -> gnt same cycle, rvalid+rdata=0xDEADBEEF next.
//  prog_mode_i=1, 3 back-to-back prog writes (depth 2) while SRAM busy popping -> all 3 written at 0x000..0x002,
//   prog_ovf_o stays 0; bus_req_i held throughout -> gnt=0 until DRAIN->RUN.
//  RUN, bus_req_i held, prog writes every cycle -> bus granted on the 5th cycle (STARVE_MAX=4), cnt clears.
//  Force push while full and no pop (stall via continuous forced bus wins) -> word dropped, prog_ovf_o=1 sticky.
//  Assert rst_i mid-DRAIN with 2 buffered words -> outputs at reset values, no SRAM write after release.
//  ICCM_ARB_WCOUNT_EN: 5 prog writes in session -> prog_wcount_o=5; re-enter PROG -> 0.

Source files
------------

// File: rtl/iccm_port_arbiter.sv
// iccm_port_arbiter: shares the 1rw ICCM SRAM between the boot-programming write buffer and the TL-UL bus.
// Latency: SRAM access in the grant/pop cycle; bus response (rvalid/rdata) exactly 1 cycle after grant.
// Backpressure: bus held off via bus_gnt_o; prog writes never stall, dropped with sticky prog_ovf_o when full.
// Optional macro ICCM_ARB_WCOUNT_EN adds prog_wcount_o (count of committed programming writes).

// iccm_arb_fifo: small generic FIFO holding programming writes.
// Latency: pushed word visible at the head the cycle after push.
// Backpressure: none internally; the caller must not push when full without a simultaneous pop.
module iccm_arb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= wdata;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_q[rd_ptr];
endmodule

module iccm_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int PBUF_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            prog_mode_i,
  input  logic            prog_we_i,
  input  logic [AW-1:0]   prog_addr_i,
  input  logic [DW-1:0]   prog_wdata_i,
  output logic            prog_full_o,
  output logic            prog_ovf_o,
  input  logic            bus_req_i,
  input  logic            bus_we_i,
  input  logic [AW-1:0]   bus_addr_i,
  input  logic [DW-1:0]   bus_wdata_i,
  input  logic [DW/8-1:0] bus_wmask_i,
  output logic            bus_gnt_o,
  output logic            bus_rvalid_o,
  output logic [DW-1:0]   bus_rdata_o,
  output logic            sram_csb_o,
  output logic            sram_web_o,
  output logic [DW/8-1:0] sram_wmask_o,
  output logic [AW-1:0]   sram_addr_o,
  output logic [DW-1:0]   sram_din_o,
  input  logic [DW-1:0]   sram_dout_i,
`ifdef ICCM_ARB_WCOUNT_EN
  output logic [AW:0]     prog_wcount_o,
`endif
  output logic            busy_o
);
  localparam int CW = $clog2(PBUF_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {RUN, PROG, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count;
  logic [AW+DW-1:0]   head;
  logic               buf_empty, buf_full;
  logic               pop, push, gnt;
  logic [SW-1:0]      starve_q;
  logic               ovf_q, rvalid_q, rd_q;

  assign buf_empty = (count == '0);
  assign buf_full  = (count == CW'(PBUF_DEPTH));
  // a full buffer still accepts a word when the head leaves in the same cycle
  assign push      = prog_we_i && (!buf_full || pop);

  iccm_arb_fifo #(.W(AW + DW), .DEPTH(PBUF_DEPTH)) u_pbuf (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata ({prog_addr_i, prog_wdata_i}),
    .rdata (head),
    .count (count)
  );

  // session state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // next state, per-cycle arbitration and SRAM drive; nothing is granted while reset is held
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    gnt          = 1'b0;
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    unique case (state_q)
      RUN:     if (prog_mode_i) state_d = PROG;
      PROG:    if (!prog_mode_i) state_d = DRAIN;
      DRAIN: begin
        if (prog_mode_i)                 state_d = PROG;
        else if (buf_empty && !push)     state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (!rst_i) begin
      if (state_q != RUN)                                    pop = !buf_empty;
      else if (buf_empty)                                    gnt = bus_req_i;
      else if (bus_req_i && starve_q == SW'(STARVE_MAX))     gnt = 1'b1;
      else                                                   pop = 1'b1;
    end
    if (pop) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = 1'b0;
      sram_wmask_o = '1;
      sram_addr_o  = head[AW+DW-1:DW];
      sram_din_o   = head[DW-1:0];
    end else if (gnt) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = !bus_we_i;
      sram_wmask_o = bus_we_i ? bus_wmask_i : '0;
      sram_addr_o  = bus_addr_i;
      sram_din_o   = bus_wdata_i;
    end
  end

  // starvation counter: counts denied request cycles, saturating, cleared on grant or idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   starve_q <= '0;
    else if (bus_req_i && !gnt)  starve_q <= (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    else                         starve_q <= '0;
  end

  // response pipeline and sticky overflow flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rd_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      rd_q     <= gnt && !bus_we_i;
      if (prog_we_i && !push) ovf_q <= 1'b1;
    end
  end

`ifdef ICCM_ARB_WCOUNT_EN
  logic [AW:0] wcount_q;

  // committed programming writes in the current session, saturating
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  wcount_q <= '0;
    else if (state_q == RUN && state_d == PROG) wcount_q <= '0;
    else if (pop && wcount_q != '1)             wcount_q <= wcount_q + 1'b1;
  end

  assign prog_wcount_o = wcount_q;
`endif

  assign bus_gnt_o    = gnt;
  assign bus_rvalid_o = rvalid_q;
  assign bus_rdata_o  = rd_q ? sram_dout_i : '0;
  assign prog_full_o  = buf_full;
  assign prog_ovf_o   = ovf_q;
  assign busy_o       = (state_q != RUN) || !buf_empty;
endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Bench for iccm_port_arbiter: table vectors, directed corner sequences, randomized run vs reference model.
module tb_iccm_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int PBUF_DEPTH = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prog_mode = 1'b0, prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_wdata = '0;
  logic prog_full, prog_ovf;
  logic bus_req = 1'b0, bus_we = 1'b0;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_wdata = '0;
  logic [3:0] bus_wmask = '0;
  logic bus_gnt, bus_rvalid;
  logic [DW-1:0] bus_rdata;
  logic sram_csb, sram_web;
  logic [3:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;
  logic busy;
`ifdef ICCM_ARB_WCOUNT_EN
  logic [AW:0] prog_wcount;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  iccm_port_arbiter #(.AW(AW), .DW(DW), .PBUF_DEPTH(PBUF_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst), .prog_mode_i(prog_mode), .prog_we_i(prog_we),
    .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata), .prog_full_o(prog_full), .prog_ovf_o(prog_ovf),
    .bus_req_i(bus_req), .bus_we_i(bus_we), .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata),
    .bus_wmask_i(bus_wmask), .bus_gnt_o(bus_gnt), .bus_rvalid_o(bus_rvalid), .bus_rdata_o(bus_rdata),
    .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_wmask_o(sram_wmask), .sram_addr_o(sram_addr),
    .sram_din_o(sram_din), .sram_dout_i(sram_dout),
`ifdef ICCM_ARB_WCOUNT_EN
    .prog_wcount_o(prog_wcount),
`endif
    .busy_o(busy));

  function automatic logic [31:0] init_val(int i);
    return (i == 16) ? 32'hDEADBEEF : (32'h5A00_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] pdat(logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // SRAM macro model: 1rw, byte-masked writes, read data registered
  logic [DW-1:0] mem [0:1023];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  // reference model: queue of pending words, session phase, denied-cycle counter, golden memory
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} pw_t;
  pw_t mq[$];
  int m_state = 0;   // 0 normal, 1 programming, 2 draining
  int m_starve = 0;
  bit m_ovf = 0, m_rv = 0, m_rd = 0, g_init = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] gold [0:1023];

  function automatic void decide(output bit pop, output bit gnt);
    pop = 0; gnt = 0;
    if (rst) return;
    if (m_state != 0)                                pop = (mq.size() != 0);
    else if (mq.size() == 0)                         gnt = bus_req;
    else if (bus_req && m_starve == STARVE_MAX)      gnt = 1;
    else                                             pop = 1;
  endfunction

  always @(posedge clk or posedge rst) begin : ref_model
    bit pop, gnt;
    int n;
    pw_t h;
    if (!g_init) begin
      for (int i = 0; i < 1024; i++) gold[i] = init_val(i);
      g_init = 1;
    end
    if (rst) begin
      mq.delete(); m_state = 0; m_starve = 0; m_ovf = 0; m_rv = 0; m_rd = 0; m_rdata = '0;
    end else begin
      decide(pop, gnt);
      n = mq.size();
      m_rdata = gold[bus_addr];
      m_rv = gnt;
      m_rd = gnt && !bus_we;
      if (pop) begin h = mq.pop_front(); gold[h.a] = h.d; end
      if (gnt && bus_we)
        for (int b = 0; b < 4; b++) if (bus_wmask[b]) gold[bus_addr][8*b +: 8] = bus_wdata[8*b +: 8];
      if (prog_we) begin
        if (n == PBUF_DEPTH && !pop) m_ovf = 1;
        else mq.push_back(pw_t'({prog_addr, prog_wdata}));
      end
      if (bus_req && !gnt) m_starve = (m_starve == STARVE_MAX) ? m_starve : m_starve + 1;
      else m_starve = 0;
      case (m_state)
        0: if (prog_mode) m_state = 1;
        1: if (!prog_mode) m_state = 2;
        default: if (prog_mode) m_state = 1; else if (n == 0 && !prog_we) m_state = 0;
      endcase
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // drive one cycle of inputs just after the falling edge, sample 1 time unit later
  task automatic drive(logic pm, logic pwe, logic [AW-1:0] pa, logic req, logic we, logic [AW-1:0] ba);
    @(negedge clk);
    prog_mode = pm; prog_we = pwe; prog_addr = pa; prog_wdata = pdat(pa);
    bus_req = req; bus_we = we; bus_addr = ba; bus_wdata = 32'h1234_5678; bus_wmask = 4'hF;
    #1;
  endtask

  task automatic check_model(output bit pend);
    bit pop, gnt;
    logic e_csb, e_web;
    logic [3:0] e_wm;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    decide(pop, gnt);
    e_csb = 1; e_web = 1; e_wm = '0; e_a = '0; e_d = '0;
    if (pop) begin
      e_csb = 0; e_web = 0; e_wm = 4'hF; e_a = mq[0].a; e_d = mq[0].d;
    end else if (gnt) begin
      e_csb = 0; e_web = !bus_we; e_wm = bus_we ? bus_wmask : 4'h0; e_a = bus_addr; e_d = bus_wdata;
    end
    chk("r_gnt", 32'(bus_gnt), 32'(gnt));
    chk("r_csb", 32'(sram_csb), 32'(e_csb));
    chk("r_web", 32'(sram_web), 32'(e_web));
    chk("r_wmask", 32'(sram_wmask), 32'(e_wm));
    chk("r_addr", 32'(sram_addr), 32'(e_a));
    chk("r_din", sram_din, e_d);
    chk("r_rvalid", 32'(bus_rvalid), 32'(m_rv));
    chk("r_rdata", bus_rdata, (m_rv && m_rd) ? m_rdata : 32'h0);
    chk("r_full", 32'(prog_full), 32'(mq.size() == PBUF_DEPTH));
    chk("r_ovf", 32'(prog_ovf), 32'(m_ovf));
    chk("r_busy", 32'(busy), 32'(m_state != 0 || mq.size() != 0));
    pend = bus_req && !gnt;
  endtask

  typedef struct {
    logic pwe; logic [AW-1:0] pa; logic req; logic we; logic [AW-1:0] ba;
    logic e_gnt, e_csb, e_web; logic [AW-1:0] e_addr; logic e_rv; logic [DW-1:0] e_rd; logic e_full, e_busy;
  } vec_t;

  function automatic vec_t mkv(logic pwe, logic [AW-1:0] pa, logic req, logic we, logic [AW-1:0] ba,
                               logic g, logic c, logic w, logic [AW-1:0] ea, logic rv, logic [DW-1:0] rd,
                               logic f, logic bz);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.req = req; v.we = we; v.ba = ba;
    v.e_gnt = g; v.e_csb = c; v.e_web = w; v.e_addr = ea; v.e_rv = rv; v.e_rd = rd; v.e_full = f; v.e_busy = bz;
    return v;
  endfunction

  vec_t vt [13];

  initial begin
    bit pend;
    // read, then starvation with a prog write every cycle
    vt[0]  = mkv(0, 10'h000, 0, 0, 10'h000,  0, 1, 1, 10'h000, 0, 32'h0, 0, 0);
    vt[1]  = mkv(0, 10'h000, 1, 0, 10'h010,  1, 0, 1, 10'h010, 0, 32'h0, 0, 0);
    vt[2]  = mkv(0, 10'h000, 0, 0, 10'h000,  0, 1, 1, 10'h000, 1, 32'hDEADBEEF, 0, 0);
    vt[3]  = mkv(0, 10'h000, 0, 0, 10'h000,  0, 1, 1, 10'h000, 0, 32'h0, 0, 0);
    vt[4]  = mkv(1, 10'h100, 0, 0, 10'h000,  0, 1, 1, 10'h000, 0, 32'h0, 0, 0);
    vt[5]  = mkv(1, 10'h101, 1, 1, 10'h020,  0, 0, 0, 10'h100, 0, 32'h0, 0, 1);
    vt[6]  = mkv(1, 10'h102, 1, 1, 10'h020,  0, 0, 0, 10'h101, 0, 32'h0, 0, 1);
    vt[7]  = mkv(1, 10'h103, 1, 1, 10'h020,  0, 0, 0, 10'h102, 0, 32'h0, 0, 1);
    vt[8]  = mkv(1, 10'h104, 1, 1, 10'h020,  0, 0, 0, 10'h103, 0, 32'h0, 0, 1);
    vt[9]  = mkv(1, 10'h105, 1, 1, 10'h020,  1, 0, 0, 10'h020, 0, 32'h0, 0, 1);
    vt[10] = mkv(0, 10'h000, 0, 0, 10'h000,  0, 0, 0, 10'h104, 1, 32'h0, 1, 1);
    vt[11] = mkv(0, 10'h000, 0, 0, 10'h000,  0, 0, 0, 10'h105, 0, 32'h0, 0, 1);
    vt[12] = mkv(0, 10'h000, 0, 0, 10'h000,  0, 1, 1, 10'h000, 0, 32'h0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(bus_gnt), 0);     chk("rst_rvalid", 32'(bus_rvalid), 0);
    chk("rst_rdata", bus_rdata, 0);      chk("rst_csb", 32'(sram_csb), 1);
    chk("rst_web", 32'(sram_web), 1);    chk("rst_full", 32'(prog_full), 0);
    chk("rst_ovf", 32'(prog_ovf), 0);    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(0, vt[i].pwe, vt[i].pa, vt[i].req, vt[i].we, vt[i].ba);
      chk($sformatf("v%0d_gnt", i), 32'(bus_gnt), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d_csb", i), 32'(sram_csb), 32'(vt[i].e_csb));
      chk($sformatf("v%0d_web", i), 32'(sram_web), 32'(vt[i].e_web));
      chk($sformatf("v%0d_addr", i), 32'(sram_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d_rvalid", i), 32'(bus_rvalid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d_rdata", i), bus_rdata, vt[i].e_rd);
      chk($sformatf("v%0d_full", i), 32'(prog_full), 32'(vt[i].e_full));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
    end

    // programming session: 3 back-to-back words, bus held off until the drain completes
    for (int c = 0; c < 8; c++) begin
      drive(c <= 3, c >= 1 && c <= 3, 10'(c - 1), c >= 1 && c <= 6, 0, 10'h3F0);
      if (c < 7) chk($sformatf("s1_gnt%0d", c), 32'(bus_gnt), 32'(c == 6));
      chk($sformatf("s1_ovf%0d", c), 32'(prog_ovf), 0);
    end
    chk("s1_rvalid", 32'(bus_rvalid), 1);
    chk("s1_rdata", bus_rdata, init_val(10'h3F0));
    drive(0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 3; a++) chk($sformatf("s1_mem%0d", a), mem[a], pdat(10'(a)));

    // overflow: forced bus wins while the buffer is full
    for (int c = 0; c < 14; c++) begin
      drive(0, c <= 10, 10'(10'h200 + c), c >= 1 && c <= 10, 0, 10'h3F0);
      chk($sformatf("s2_gnt%0d", c), 32'(bus_gnt), 32'(c == 5 || c == 10));
      chk($sformatf("s2_ovf%0d", c), 32'(prog_ovf), 32'(c >= 11));
      if (c >= 6 && c <= 9) chk($sformatf("s2_full%0d", c), 32'(prog_full), 1);
    end
    chk("s2_mem209", mem[10'h209], pdat(10'h209));
    chk("s2_mem20a", mem[10'h20A], init_val(10'h20A));

    // reset while draining two buffered words
    for (int d = 0; d < 7; d++) begin
      drive(d == 5, 1, 10'(10'h280 + d), d >= 1 && d <= 5, 0, 10'h3F0);
      if (d == 5) chk("s3_gnt5", 32'(bus_gnt), 1);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("s3_busy", 32'(busy), 1);
    chk("s3_full", 32'(prog_full), 1);
    chk("s3_pop_addr", 32'(sram_addr), 32'h285);
    #1 rst = 1'b1;
    #1;
    chk("s3r_gnt", 32'(bus_gnt), 0);     chk("s3r_rvalid", 32'(bus_rvalid), 0);
    chk("s3r_rdata", bus_rdata, 0);      chk("s3r_csb", 32'(sram_csb), 1);
    chk("s3r_web", 32'(sram_web), 1);    chk("s3r_wmask", 32'(sram_wmask), 0);
    chk("s3r_addr", 32'(sram_addr), 0);  chk("s3r_din", sram_din, 0);
    chk("s3r_full", 32'(prog_full), 0);  chk("s3r_ovf", 32'(prog_ovf), 0);
    chk("s3r_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("s3_idle_csb%0d", i), 32'(sram_csb), 1);
    end
    chk("s3_mem284", mem[10'h284], pdat(10'h284));
    chk("s3_mem285", mem[10'h285], init_val(10'h285));
    chk("s3_mem286", mem[10'h286], init_val(10'h286));

`ifdef ICCM_ARB_WCOUNT_EN
    // commit counter: 5 writes in a session, cleared on re-entry
    for (int e = 0; e < 8; e++) drive(e <= 5, e >= 1 && e <= 5, 10'(10'h300 + e), 0, 0, 0);
    chk("wc_five", 32'(prog_wcount), 5);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("wc_clear", 32'(prog_wcount), 0);
    for (int e = 0; e < 3; e++) drive(0, 0, 0, 0, 0, 0);
`endif

    // randomized traffic against the reference model
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) prog_mode = !prog_mode;
      prog_we = ($urandom_range(0, 2) != 0);
      prog_addr = 10'($urandom_range(0, 63));
      prog_wdata = $urandom();
      if (!pend) begin
        bus_req = 1'($urandom_range(0, 1));
        bus_we = 1'($urandom_range(0, 1));
        bus_addr = 10'($urandom_range(0, 63));
        bus_wdata = $urandom();
        bus_wmask = 4'($urandom_range(0, 15));
      end
      #1;
      check_model(pend);
    end
    @(negedge clk);
    rst = 1'b0; prog_mode = 0; prog_we = 0; bus_req = 0;
    repeat (6) @(negedge clk);
    begin
      int nbad;
      nbad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== gold[i]) nbad++;
      chk("mem_image_mismatches", 32'(nbad), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
